lc3_execute: RTL and testbench

LC3_EXECUTE -- requirements
Module: lc3_execute

---
 rtl/lc3_execute_if.sv | 59 +++++
 rtl/lc3_execute.sv | 111 +++++++++++
 tb/tb_lc3_execute.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_execute_if.sv
// Decode-to-execute bundle for lc3_execute; optional forwarding signals
// appear only when LC3_EXEC_BYPASS_EN is defined.
interface lc3_execute_if;
  logic        enable_execute;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] M_Data;
  logic [15:0] IR_Exec;
  logic [2:0]  dr;
  logic [2:0]  NZP;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
`ifdef LC3_EXEC_BYPASS_EN
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [15:0] Mem_Bypass_Val;

  modport master (
    output enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           Mem_Bypass_Val,
    input  sr1, sr2, aluout, pcout, M_Data, IR_Exec, dr, NZP, W_Control_out,
           Mem_Control_out
  );

  modport slave (
    input  enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           Mem_Bypass_Val,
    output sr1, sr2, aluout, pcout, M_Data, IR_Exec, dr, NZP, W_Control_out,
           Mem_Control_out
  );
`else
  modport master (
    output enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
           VSR1, VSR2,
    input  sr1, sr2, aluout, pcout, M_Data, IR_Exec, dr, NZP, W_Control_out,
           Mem_Control_out
  );

  modport slave (
    input  enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
           VSR1, VSR2,
    output sr1, sr2, aluout, pcout, M_Data, IR_Exec, dr, NZP, W_Control_out,
           Mem_Control_out
  );
`endif
endinterface

// File: rtl/lc3_execute.sv
// LC-3 execute stage: ALU, address adder and the execute pipeline register.
// Define LC3_EXEC_BYPASS_EN to compile in operand forwarding.
module lc3_execute (
  input logic          clock,
  input logic          reset,
  lc3_execute_if.slave ex
);

  logic [3:0]  opcode;
  logic [1:0]  alu_control;
  logic [1:0]  pcselect1;
  logic        pcselect2;
  logic        op2select;
  logic [15:0] op1_reg;
  logic [15:0] op2_reg;
  logic [15:0] operand_b;
  logic [15:0] alu_result;
  logic [15:0] pc_offset;
  logic [15:0] pc_base;
  logic [15:0] address;
  logic [2:0]  next_dr;
  logic [2:0]  next_nzp;

  assign opcode      = ex.IR[15:12];
  assign alu_control = ex.E_Control[5:4];
  assign pcselect1   = ex.E_Control[3:2];
  assign pcselect2   = ex.E_Control[1];
  assign op2select   = ex.E_Control[0];

  // Stores (ST/STR/STI) read the data register through sr2.
  assign ex.sr1 = ex.IR[8:6];
  assign ex.sr2 = (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011)
                  ? ex.IR[11:9] : ex.IR[2:0];

`ifdef LC3_EXEC_BYPASS_EN
  assign op1_reg = ex.bypass_alu_1 ? ex.aluout :
                   ex.bypass_mem_1 ? ex.Mem_Bypass_Val : ex.VSR1;
  assign op2_reg = ex.bypass_alu_2 ? ex.aluout :
                   ex.bypass_mem_2 ? ex.Mem_Bypass_Val : ex.VSR2;
`else
  assign op1_reg = ex.VSR1;
  assign op2_reg = ex.VSR2;
`endif

  assign operand_b = op2select ? op2_reg : {{11{ex.IR[4]}}, ex.IR[4:0]};

  always_comb begin
    alu_result = 16'h0000;
    case (alu_control)
      2'b00:   alu_result = op1_reg + operand_b;
      2'b01:   alu_result = op1_reg & operand_b;
      2'b10:   alu_result = ~op1_reg;
      default: alu_result = 16'h0000;
    endcase
  end

  always_comb begin
    pc_offset = 16'h0000;
    case (pcselect1)
      2'b00:   pc_offset = {{5{ex.IR[10]}}, ex.IR[10:0]};
      2'b01:   pc_offset = {{7{ex.IR[8]}}, ex.IR[8:0]};
      2'b10:   pc_offset = {{10{ex.IR[5]}}, ex.IR[5:0]};
      default: pc_offset = 16'h0000;
    endcase
  end

  assign pc_base = pcselect2 ? ex.npc_in : op1_reg;
  assign address = pc_base + pc_offset;

  always_comb begin
    next_dr = 3'b000;
    case (opcode)
      4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010, 4'b1110:
        next_dr = ex.IR[11:9];
      default: next_dr = 3'b000;
    endcase
  end

  always_comb begin
    next_nzp = 3'b000;
    case (opcode)
      4'b0000: next_nzp = ex.IR[11:9];
      4'b1100: next_nzp = 3'b111;
      default: next_nzp = 3'b000;
    endcase
  end

  // Reset wins over enable, so an in-flight instruction is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex.aluout          <= 16'h0000;
      ex.pcout           <= 16'h0000;
      ex.M_Data          <= 16'h0000;
      ex.IR_Exec         <= 16'h0000;
      ex.dr              <= 3'b000;
      ex.NZP             <= 3'b000;
      ex.W_Control_out   <= 2'b00;
      ex.Mem_Control_out <= 1'b0;
    end else if (ex.enable_execute) begin
      ex.aluout          <= (opcode == 4'b1110) ? address : alu_result;
      ex.pcout           <= address;
      ex.M_Data          <= op2_reg;
      ex.IR_Exec         <= ex.IR;
      ex.dr              <= next_dr;
      ex.NZP             <= next_nzp;
      ex.W_Control_out   <= ex.W_Control_in;
      ex.Mem_Control_out <= ex.Mem_Control_in;
    end
  end

endmodule

// File: tb/tb_lc3_execute.sv
// Self-checking bench for lc3_execute: directed cases plus a randomized run
// against a behavioural model of the execute stage.
module tb_lc3_execute;

  typedef struct packed {
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] m_data;
    logic [15:0] ir_exec;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [1:0]  w;
    logic        m;
  } exp_t;

  logic clock;
  logic reset;
  int   check_count;
  int   pass_count;
  logic ba1, ba2, bm1, bm2;
  logic [15:0] mbv;

  lc3_execute_if ex ();

  lc3_execute dut (
    .clock (clock),
    .reset (reset),
    .ex    (ex.slave)
  );

`ifdef LC3_EXEC_BYPASS_EN
  assign ex.bypass_alu_1   = ba1;
  assign ex.bypass_alu_2   = ba2;
  assign ex.bypass_mem_1   = bm1;
  assign ex.bypass_mem_2   = bm2;
  assign ex.Mem_Bypass_Val = mbv;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: what the stage should latch, written from the ISA rules.
  function automatic exp_t model_load(input logic [15:0] ir, input logic [15:0] npc,
                                      input logic [5:0] ec, input logic [1:0] w,
                                      input logic m, input logic [15:0] v1,
                                      input logic [15:0] v2, input logic [15:0] prev_alu);
    exp_t r;
    int op, a, b, off, base, res, addr;
    op = int'(ir[15:12]);
`ifdef LC3_EXEC_BYPASS_EN
    a = ba1 ? int'(prev_alu) : (bm1 ? int'(mbv) : int'(v1));
    b = ba2 ? int'(prev_alu) : (bm2 ? int'(mbv) : int'(v2));
`else
    a = int'(v1);
    b = int'(v2);
    if (prev_alu === 16'hxxxx) a = 0;
`endif
    r.m_data = b[15:0];
    if (ec[0] == 1'b0) begin
      b = $signed(ir[4:0]);
      b = b & 65535;
    end
    case (ec[5:4])
      2'd0: res = (a + b) % 65536;
      2'd1: res = a & b;
      2'd2: res = 65535 - a;
      default: res = 0;
    endcase
    case (ec[3:2])
      2'd0: off = $signed(ir[10:0]);
      2'd1: off = $signed(ir[8:0]);
      2'd2: off = $signed(ir[5:0]);
      default: off = 0;
    endcase
    base = ec[1] ? int'(npc) : a;
    addr = (base + off + 65536) % 65536;
    r.pcout   = addr[15:0];
    r.aluout  = (op == 14) ? addr[15:0] : res[15:0];
    r.ir_exec = ir;
    r.dr      = (op inside {1, 5, 9, 2, 6, 10, 14}) ? ir[11:9] : 3'd0;
    r.nzp     = (op == 0) ? ir[11:9] : ((op == 12) ? 3'b111 : 3'd0);
    r.w       = w;
    r.m       = m;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] ir, input logic [5:0] ec,
                       input logic [15:0] npc, input logic [15:0] v1, input logic [15:0] v2,
                       input logic [1:0] w, input logic m);
    ex.enable_execute = en;
    ex.IR             = ir;
    ex.E_Control      = ec;
    ex.npc_in         = npc;
    ex.VSR1           = v1;
    ex.VSR2           = v2;
    ex.W_Control_in   = w;
    ex.Mem_Control_in = m;
  endtask

  task automatic test_reset();
    logic [15:0] ir;
    logic [2:0] exp_sr2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ir = 16'($urandom);
      drive(1'b1, ir, 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), 1'($urandom));
      tick();
      check_count++;
      if ({ex.aluout, ex.pcout, ex.M_Data, ex.IR_Exec, ex.dr, ex.NZP, ex.W_Control_out,
           ex.Mem_Control_out} !== 76'd0)
        $display("[TB] FAIL reset_outputs: got aluout=%h pcout=%h M_Data=%h IR_Exec=%h dr=%0d NZP=%b expected all 0",
                 ex.aluout, ex.pcout, ex.M_Data, ex.IR_Exec, ex.dr, ex.NZP);
      else pass_count++;
      exp_sr2 = (ir[15:12] inside {4'd3, 4'd7, 4'd11}) ? ir[11:9] : ir[2:0];
      check_count++;
      if (ex.sr1 !== ir[8:6] || ex.sr2 !== exp_sr2)
        $display("[TB] FAIL reset_sr: got sr1=%0d sr2=%0d expected sr1=%0d sr2=%0d",
                 ex.sr1, ex.sr2, ir[8:6], exp_sr2);
      else pass_count++;
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive(1'b1, 16'h1042, 6'b001111, 16'h3000, 16'd5, 16'd7, 2'b10, 1'b1);
    #1;
    check_count++;
    if (ex.sr1 !== 3'd1 || ex.sr2 !== 3'd2)
      $display("[TB] FAIL add_sr: got sr1=%0d sr2=%0d expected 1 2", ex.sr1, ex.sr2);
    else pass_count++;
    tick();
    check_count++;
    if (ex.aluout !== 16'd12 || ex.dr !== 3'd0 || ex.NZP !== 3'd0 || ex.IR_Exec !== 16'h1042)
      $display("[TB] FAIL add_result: got aluout=%0d dr=%0d NZP=%b IR_Exec=%h expected 12 0 000 1042",
               ex.aluout, ex.dr, ex.NZP, ex.IR_Exec);
    else pass_count++;
    check_count++;
    if (ex.pcout !== 16'h3000 || ex.M_Data !== 16'd7 || ex.W_Control_out !== 2'b10 ||
        ex.Mem_Control_out !== 1'b1)
      $display("[TB] FAIL add_side: got pcout=%h M_Data=%h W=%b M=%b expected 3000 0007 10 1",
               ex.pcout, ex.M_Data, ex.W_Control_out, ex.Mem_Control_out);
    else pass_count++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), 1'($urandom));
      tick();
      check_count++;
      if (ex.aluout !== 16'd12 || ex.pcout !== 16'h3000 || ex.M_Data !== 16'd7 ||
          ex.IR_Exec !== 16'h1042 || ex.dr !== 3'd0 || ex.NZP !== 3'd0 ||
          ex.W_Control_out !== 2'b10 || ex.Mem_Control_out !== 1'b1)
        $display("[TB] FAIL hold: got aluout=%h pcout=%h M_Data=%h IR_Exec=%h W=%b M=%b expected 000c 3000 0007 1042 10 1",
                 ex.aluout, ex.pcout, ex.M_Data, ex.IR_Exec, ex.W_Control_out, ex.Mem_Control_out);
      else pass_count++;
    end
  endtask

  task automatic test_and_imm();
    drive(1'b1, 16'h573F, 6'b011110, 16'h1234, 16'h00F0, 16'hAAAA, 2'b01, 1'b0);
    tick();
    check_count++;
    if (ex.aluout !== 16'h00F0 || ex.dr !== 3'd3)
      $display("[TB] FAIL and_imm: got aluout=%h dr=%0d expected 00f0 3", ex.aluout, ex.dr);
    else pass_count++;
  endtask

  task automatic test_branch();
    drive(1'b1, 16'h0DFE, 6'b000110, 16'h3005, 16'h4444, 16'h5555, 2'b00, 1'b0);
    tick();
    check_count++;
    if (ex.pcout !== 16'h3003 || ex.NZP !== 3'b110 || ex.dr !== 3'd0)
      $display("[TB] FAIL branch: got pcout=%h NZP=%b dr=%0d expected 3003 110 0",
               ex.pcout, ex.NZP, ex.dr);
    else pass_count++;
  endtask

`ifdef LC3_EXEC_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 16'h1042, 6'b001111, 16'h3000, 16'd5, 16'd7, 2'b10, 1'b1);
    tick();
    drive(1'b1, 16'h1042, 6'b001111, 16'h3000, 16'd100, 16'd1, 2'b10, 1'b1);
    ba1 = 1'b1;
    bm1 = 1'b1;
    mbv = 16'h0200;
    tick();
    check_count++;
    if (ex.aluout !== 16'd13)
      $display("[TB] FAIL bypass_priority: got aluout=%0d expected 13", ex.aluout);
    else pass_count++;
    ba1 = 1'b0;
    bm1 = 1'b0;
  endtask
`endif

  task automatic test_random();
    exp_t e, nx;
    logic [2:0] exp_sr2;
    e = '0;
    for (int i = 0; i < 400; i++) begin
      reset = (i == 0) || ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 3) != 0), 16'($urandom), 6'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
`ifdef LC3_EXEC_BYPASS_EN
      ba1 = 1'($urandom); ba2 = 1'($urandom);
      bm1 = 1'($urandom); bm2 = 1'($urandom);
      mbv = 16'($urandom);
`endif
      #1;
      exp_sr2 = (ex.IR[15:12] inside {4'd3, 4'd7, 4'd11}) ? ex.IR[11:9] : ex.IR[2:0];
      check_count++;
      if (ex.sr1 !== ex.IR[8:6] || ex.sr2 !== exp_sr2)
        $display("[TB] FAIL rand_sr: IR=%h got sr1=%0d sr2=%0d expected %0d %0d",
                 ex.IR, ex.sr1, ex.sr2, ex.IR[8:6], exp_sr2);
      else pass_count++;
      if (reset) nx = '0;
      else if (ex.enable_execute)
        nx = model_load(ex.IR, ex.npc_in, ex.E_Control, ex.W_Control_in, ex.Mem_Control_in,
                        ex.VSR1, ex.VSR2, e.aluout);
      else nx = e;
      tick();
      e = nx;
      check_count++;
      if (ex.aluout !== e.aluout || ex.pcout !== e.pcout)
        $display("[TB] FAIL rand_alu_pc: cycle %0d got aluout=%h pcout=%h expected %h %h",
                 i, ex.aluout, ex.pcout, e.aluout, e.pcout);
      else pass_count++;
      check_count++;
      if (ex.M_Data !== e.m_data || ex.IR_Exec !== e.ir_exec)
        $display("[TB] FAIL rand_mdata_ir: cycle %0d got M_Data=%h IR_Exec=%h expected %h %h",
                 i, ex.M_Data, ex.IR_Exec, e.m_data, e.ir_exec);
      else pass_count++;
      check_count++;
      if (ex.dr !== e.dr || ex.NZP !== e.nzp)
        $display("[TB] FAIL rand_dr_nzp: cycle %0d got dr=%0d NZP=%b expected %0d %b",
                 i, ex.dr, ex.NZP, e.dr, e.nzp);
      else pass_count++;
      check_count++;
      if (ex.W_Control_out !== e.w || ex.Mem_Control_out !== e.m)
        $display("[TB] FAIL rand_ctrl: cycle %0d got W=%b M=%b expected %b %b",
                 i, ex.W_Control_out, ex.Mem_Control_out, e.w, e.m);
      else pass_count++;
    end
    reset = 1'b0;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset = 1'b1;
    ba1 = 1'b0; ba2 = 1'b0; bm1 = 1'b0; bm2 = 1'b0;
    mbv = 16'h0000;
    drive(1'b0, 16'h0000, 6'd0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    test_reset();
    test_add();
    test_hold();
    test_and_imm();
    test_branch();
`ifdef LC3_EXEC_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
